// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - upstream/downstream handshake bundle for imm_gen_stage
interface imm_gen_stage_if #(
  parameter int XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [31:0]     out_inst;

  modport master (
    output in_valid, in_op, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_inst
  );

  modport slave (
    input  in_valid, in_op, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_inst
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with 2-entry skid buffer
// Optional macro IMM_GEN_FLUSH_EN adds a flush input that empties both slots.
module imm_gen_stage #(
  parameter int XLEN = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef IMM_GEN_FLUSH_EN
  input  logic flush,
`endif
  imm_gen_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;

  logic            w_flush;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [5:0]      w_shamt;
  logic            w_sign;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_imm;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_pop;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic [31:0]     r_out_inst;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic [31:0]     r_skid_inst;

`ifdef IMM_GEN_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_opcode   = bus.in_inst[6:0];
  assign w_funct3   = bus.in_inst[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_sign     = bus.in_inst[31];
  // RV64 shamt carries bit 25; RV32 stops at bit 24
  assign w_shamt    = (XLEN == 64) ? bus.in_inst[25:20] : {1'b0, bus.in_inst[24:20]};

  // Built at 64 bits and truncated, which equals sign-extension to XLEN
  always_comb begin
    w_imm64 = '0;
    case (bus.in_op)
      3'b001: begin
        if (w_opcode == OPC_OP_IMM && w_is_shift)
          w_imm64 = {58'b0, w_shamt};
        else if (w_opcode == OPC_OP_IMM32 && w_is_shift)
          w_imm64 = {59'b0, bus.in_inst[24:20]};
        else
          w_imm64 = {{52{w_sign}}, bus.in_inst[31:20]};
      end
      3'b010: w_imm64 = {{52{w_sign}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      3'b011: w_imm64 = {{51{w_sign}}, bus.in_inst[31], bus.in_inst[7],
                         bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      3'b100: w_imm64 = {{32{w_sign}}, bus.in_inst[31:12], 12'b0};
      3'b101: begin
        if (w_opcode == OPC_JALR)
          w_imm64 = {{52{w_sign}}, bus.in_inst[31:20]};
        else
          w_imm64 = {{43{w_sign}}, bus.in_inst[31], bus.in_inst[19:12],
                     bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      end
      3'b110: w_imm64 = {59'b0, bus.in_inst[19:15]};
      default: w_imm64 = '0;
    endcase
  end

  assign w_imm      = w_imm64[XLEN-1:0];
  assign w_in_ready = !r_skid_valid && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_pop      = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_inst   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_inst  <= '0;
    end else if (w_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid) begin
      // skid is never occupied while out is empty
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_inst  <= bus.in_inst;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_out_imm    <= r_skid_imm;
        r_out_inst   <= r_skid_inst;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_imm  <= w_imm;
        r_out_inst <= bus.in_inst;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_inst  <= bus.in_inst;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_imm   = r_out_imm;
  assign bus.out_inst  = r_out_inst;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - bench for imm_gen_stage at XLEN=64 and XLEN=32
// Builds with or without IMM_GEN_FLUSH_EN.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  imm_gen_stage_if #(.XLEN(64)) b64 ();
  imm_gen_stage_if #(.XLEN(32)) b32 ();

  assign b32.in_valid  = b64.in_valid;
  assign b32.in_op     = b64.in_op;
  assign b32.in_inst   = b64.in_inst;
  assign b32.out_ready = b64.out_ready;

  imm_gen_stage #(.XLEN(64)) u_dut64 (
    .clk   (clk),
    .rst   (rst),
`ifdef IMM_GEN_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b64.slave)
  );

  imm_gen_stage #(.XLEN(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
`ifdef IMM_GEN_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b32.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] inst;
    logic [63:0] e64;
    logic [31:0] e32;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm64;
    logic [63:0] imm32;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  logic        last_acc = 1'b0;
  logic        hold_chk = 1'b0;
  logic [63:0] hold_imm;
  logic [31:0] hold_inst;

  function automatic longint sx(longint v, int n);
    if (v >= (longint'(1) <<< (n - 1))) return v - (longint'(1) <<< n);
    return v;
  endfunction

  function automatic logic [63:0] model(int xlen, logic [2:0] op, logic [31:0] inst);
    longint v = 0;
    int  opc = int'(inst[6:0]);
    int  f3  = int'(inst[14:12]);
    bit  sh  = (f3 == 1) || (f3 == 5);
    case (op)
      3'd1: begin
        if (opc == 'h13 && sh) v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
        else if (opc == 'h1B && sh) v = longint'(inst[24:20]);
        else v = sx(longint'(inst[31:20]), 12);
      end
      3'd2: v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      3'd3: v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                   + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      3'd4: v = sx(longint'(inst[31:12]) * 4096, 32);
      3'd5: begin
        if (opc == 'h67) v = sx(longint'(inst[31:20]), 12);
        else v = sx(longint'(inst[31]) * (longint'(1) <<< 20) + longint'(inst[19:12]) * 4096
                    + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      end
      3'd6: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return 64'(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe at the falling edge, then advance to just past the rising edge
  task automatic step();
    logic acc, pop;
    exp_t e;
    @(negedge clk);
    if (hold_chk) begin
      chk("stall_imm_stable", b64.out_imm, hold_imm);
      chk("stall_inst_stable", {32'b0, b64.out_inst}, {32'b0, hold_inst});
    end
    hold_chk  = !rst && !flush && b64.out_valid && !b64.out_ready;
    hold_imm  = b64.out_imm;
    hold_inst = b64.out_inst;
    chk("in_ready_32_vs_64", {63'b0, b32.in_ready}, {63'b0, b64.in_ready});
    chk("out_valid_32_vs_64", {63'b0, b32.out_valid}, {63'b0, b64.out_valid});
    acc = !rst && !flush && b64.in_valid && b64.in_ready;
    pop = !rst && b64.out_valid && b64.out_ready;
    if (pop) begin
      n_pop++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", {32'b0, b64.out_inst}, 64'hDEAD_0000_0000_0000);
      end else begin
        e = sb_q.pop_front();
        chk("pop_inst", {32'b0, b64.out_inst}, {32'b0, e.inst});
        chk("pop_imm64", b64.out_imm, e.imm64);
        chk("pop_imm32", {32'b0, b32.out_imm}, e.imm32);
      end
    end
    if (rst || flush) begin
      sb_q.delete();
    end else if (acc) begin
      e.inst  = b64.in_inst;
      e.imm64 = model(64, b64.in_op, b64.in_inst);
      e.imm32 = model(32, b64.in_op, b64.in_inst);
      sb_q.push_back(e);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic present(logic v, logic [2:0] op, logic [31:0] inst);
    b64.in_valid = v;
    b64.in_op    = op;
    b64.in_inst  = inst;
  endtask

  vec_t vt[13];

  initial begin
    int base;
    logic acc_c;
    logic [31:0] a_inst;

    vt[0]  = '{3'd1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
    vt[1]  = '{3'd1, 32'h03F01093, 64'h3F,                  32'h1F};
    vt[2]  = '{3'd1, 32'h03F0109B, 64'h1F,                  32'h1F};
    vt[3]  = '{3'd1, 32'h4020D093, 64'h2,                   32'h2};
    vt[4]  = '{3'd1, 32'hFFF01083, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
    vt[5]  = '{3'd3, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC};
    vt[6]  = '{3'd5, 32'h000080E7, 64'h0,                   32'h0};
    vt[7]  = '{3'd4, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000};
    vt[8]  = '{3'd6, 32'h3400D073, 64'h1,                   32'h1};
    vt[9]  = '{3'd2, 32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC};
    vt[10] = '{3'd5, 32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC};
    vt[11] = '{3'd0, 32'hFFFFFFFF, 64'h0,                   32'h0};
    vt[12] = '{3'd7, 32'hFFFFFFFF, 64'h0,                   32'h0};

    present(1'b0, 3'd0, 32'h0);
    b64.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_out_valid", {63'b0, b64.out_valid}, 64'h0);
    chk("reset_out_imm", b64.out_imm, 64'h0);
    chk("reset_out_inst", {32'b0, b64.out_inst}, 64'h0);
    chk("reset_in_ready", {63'b0, b64.in_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {63'b0, b64.in_ready}, 64'h1);

    // directed vectors, latency 1
    b64.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      present(1'b1, vt[i].op, vt[i].inst);
      step();
      chk("vec_accepted", {63'b0, last_acc}, 64'h1);
      chk("vec_out_valid", {63'b0, b64.out_valid}, 64'h1);
      chk("vec_imm64", b64.out_imm, vt[i].e64);
      chk("vec_imm32", {32'b0, b32.out_imm}, {32'b0, vt[i].e32});
      chk("vec_inst", {32'b0, b64.out_inst}, {32'b0, vt[i].inst});
      present(1'b0, 3'd0, 32'h0);
      step();
    end

    // backpressure: A, B fill both slots, C is held
    b64.out_ready = 1'b0;
    base = n_pop;
    a_inst = 32'h00100093;
    present(1'b1, 3'd1, a_inst);
    step();
    chk("bp_A_acc", {63'b0, last_acc}, 64'h1);
    present(1'b1, 3'd2, 32'hFE112E23);
    step();
    chk("bp_B_acc", {63'b0, last_acc}, 64'h1);
    chk("bp_in_ready_low", {63'b0, b64.in_ready}, 64'h0);
    present(1'b1, 3'd4, 32'h800000B7);
    step();
    chk("bp_C_held", {63'b0, last_acc}, 64'h0);
    chk("bp_out_is_A", {32'b0, b64.out_inst}, {32'b0, a_inst});
    step();
    chk("bp_C_held2", {63'b0, last_acc}, 64'h0);
    b64.out_ready = 1'b1;
    acc_c = 1'b0;
    for (int k = 0; k < 6 && !acc_c; k++) begin
      step();
      if (last_acc) acc_c = 1'b1;
    end
    chk("bp_C_eventually_acc", {63'b0, acc_c}, 64'h1);
    present(1'b0, 3'd0, 32'h0);
    for (int k = 0; k < 4; k++) step();
    chk("bp_pop_count", 64'(n_pop - base), 64'd3);
    chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);

    // reset with both slots full
    b64.out_ready = 1'b0;
    base = n_pop;
    present(1'b1, 3'd1, 32'h12300093);
    step();
    present(1'b1, 3'd1, 32'h45600093);
    step();
    chk("rst_full_in_ready", {63'b0, b64.in_ready}, 64'h0);
    present(1'b1, 3'd1, 32'h78900093);
    rst = 1'b1;
    step();
    chk("rst_mid_out_valid", {63'b0, b64.out_valid}, 64'h0);
    chk("rst_mid_out_imm", b64.out_imm, 64'h0);
    chk("rst_mid_in_ready", {63'b0, b64.in_ready}, 64'h0);
    rst = 1'b0;
    present(1'b0, 3'd0, 32'h0);
    b64.out_ready = 1'b1;
    #1;
    chk("rst_after_in_ready", {63'b0, b64.in_ready}, 64'h1);
    for (int k = 0; k < 3; k++) step();
    chk("rst_no_stale_pop", 64'(n_pop - base), 64'd0);

`ifdef IMM_GEN_FLUSH_EN
    b64.out_ready = 1'b0;
    base = n_pop;
    present(1'b1, 3'd1, 32'h00A00093);
    step();
    present(1'b1, 3'd1, 32'h00B00093);
    step();
    present(1'b1, 3'd1, 32'h00C00093);
    flush = 1'b1;
    step();
    flush = 1'b0;
    present(1'b0, 3'd0, 32'h0);
    chk("flush_out_valid", {63'b0, b64.out_valid}, 64'h0);
    chk("flush_in_ready", {63'b0, b64.in_ready}, 64'h1);
    b64.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("flush_no_stale_pop", 64'(n_pop - base), 64'd0);
`endif

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ri;
      ri = $urandom;
      case ($urandom_range(0, 5))
        0: ri[6:0] = 7'h13;
        1: ri[6:0] = 7'h1B;
        2: ri[6:0] = 7'h67;
        default: ;
      endcase
      present($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ri);
      b64.out_ready = ($urandom_range(0, 2) != 0);
`ifdef IMM_GEN_FLUSH_EN
      flush = ($urandom_range(0, 63) == 0);
`endif
      step();
    end
    flush = 1'b0;
    present(1'b0, 3'd0, 32'h0);
    b64.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("rand_drain_empty", 64'(sb_q.size()), 64'd0);
    chk("rand_drain_out_valid", {63'b0, b64.out_valid}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
